// File: rtl/hankel_pkg.sv
// Shared types and defaults for the Hankel sample-source path.
package hankel_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READY   = 2'd2
  } state_t;

  localparam logic [15:0] RD_ERR_DATA = 16'hFFFF;

endpackage

// File: rtl/hankel_src_ram.sv
// DEPTH x DATA_W sample store: synchronous write, registered read on rd_en, no reset.
module hankel_src_ram #(
  parameter int DATA_W = 16,
  parameter int AW     = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/hankel_src_buffer.sv
// Capture buffer feeding hankel_matrix: burst-captures DEPTH samples, then serves 1-cycle random reads.
// Optional HANKEL_SRC_MEAN_SUB_EN: legal reads return sample minus the capture mean.
module hankel_src_buffer
  import hankel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              cap_done,
  output logic              buf_rdy,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              rd_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LAST_PTR  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [DATA_W-1:0] ERR_DAT = {DATA_W{1'b1}};

  state_t            state;
  logic [ADDR_W:0]   wr_ptr;
  logic              err_sel;
  logic              wr_en;
  logic              rd_ok;
  logic              last_wr;
  logic [DATA_W-1:0] ram_q;

  assign in_ready = (state == CAPTURE);
  assign buf_rdy  = (state == READY);
  // arm has priority over a sample arriving in the same cycle
  assign wr_en    = in_ready && in_valid && !arm;
  assign last_wr  = wr_en && (wr_ptr == LAST_PTR);
  assign rd_ok    = buf_rdy && ({1'b0, addr} < DEPTH_LIM);

  hankel_src_ram #(
    .DATA_W (DATA_W),
    .AW     (AW),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (in_data),
    .rd_en   (rd && rd_ok),
    .rd_addr (addr[AW-1:0]),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      cap_done <= 1'b0;
      rd_err   <= 1'b0;
      err_sel  <= 1'b1;
    end else begin
      cap_done <= 1'b0;
      rd_err   <= rd && !rd_ok;
      // err_sel only moves on a read, so data holds between reads
      if (rd) err_sel <= !rd_ok;
      if (arm) begin
        state  <= CAPTURE;
        wr_ptr <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (last_wr) begin
          state    <= READY;
          cap_done <= 1'b1;
        end
      end
    end
  end

`ifdef HANKEL_SRC_MEAN_SUB_EN
  localparam int SUM_W = DATA_W + AW;

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] sum_nxt;
  logic [DATA_W-1:0]       mean;
  logic [DATA_W-1:0]       rd_mean;

  assign sum_nxt = sum + SUM_W'(signed'(in_data));

  // rd_mean snapshots the mean at read time so held data never shifts when a new capture lands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum     <= '0;
      mean    <= '0;
      rd_mean <= '0;
    end else begin
      if (arm) begin
        sum <= '0;
      end else if (wr_en) begin
        sum <= sum_nxt;
        if (last_wr) mean <= DATA_W'(sum_nxt >>> AW);
      end
      if (rd && rd_ok) rd_mean <= mean;
    end
  end

  assign data = err_sel ? ERR_DAT : (ram_q - rd_mean);
`else
  assign data = err_sel ? ERR_DAT : ram_q;
`endif

endmodule
